// File: rtl/int_res_arbiter_pkg.sv
// Shared types and default constants for the intermediate-results memory arbiter.
package Defines;

    localparam int DEF_NUM_REQ  = 3;
    localparam int DEF_MAX_LOCK = 16;

    localparam int ADDR_W   = 8;
    localparam int SINGLE_W = 32;
    localparam int DOUBLE_W = 64;

    typedef logic [ADDR_W-1:0]   IntResAddr_t;
    typedef logic [DOUBLE_W-1:0] IntResDouble_t;

    typedef enum logic [0:0] {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } DataWidth_t;

    // Read port bundle presented to the memory
    typedef struct packed {
        logic        en;
        IntResAddr_t addr;
        DataWidth_t  data_width;
    } MemRdIn_t;

    // Write port bundle presented to the memory
    typedef struct packed {
        logic          en;
        logic          chip_en;
        IntResAddr_t   addr;
        IntResDouble_t data;
        DataWidth_t    data_width;
    } MemWrIn_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_LOCKED = 2'd2
    } ArbState_t;

    // Single-width data lives in the low half; the upper half is forced to zero
    function automatic IntResDouble_t align_wr_data(input IntResDouble_t d, input DataWidth_t w);
        return (w == DOUBLE_WIDTH) ? d : {{(DOUBLE_W-SINGLE_W){1'b0}}, d[SINGLE_W-1:0]};
    endfunction

endpackage

// File: rtl/int_res_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after the pointer wins.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [PTR_W:0] sum_s;
    logic [PTR_W:0] idx_s;
    logic           found_s;
    logic           hit_s;

    // Scan requesters starting from the pointer, wrapping modulo NUM_REQ
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s   = {1'b0, ptr} + (PTR_W+1)'(i);
            idx_s   = (sum_s >= (PTR_W+1)'(NUM_REQ)) ? (sum_s - (PTR_W+1)'(NUM_REQ)) : sum_s;
            hit_s   = ~found_s & req[idx_s[PTR_W-1:0]];
            gnt[idx_s[PTR_W-1:0]] = hit_s;
            found_s = found_s | hit_s;
        end
    end

endmodule

// File: rtl/int_res_arbiter.sv
// Arbiter for the intermediate-results memory: independent read and write
// ports, each round-robin with an optional bounded lock.
// Optional feature: define INT_RES_ARB_STATS_EN to add per-requester
// saturating stall counters on the stall_cnt output.
module int_res_arbiter
    import Defines::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic          [NUM_REQ-1:0]   rd_req,
    input  logic          [NUM_REQ-1:0]   wr_req,
    input  logic          [NUM_REQ-1:0]   rd_lock,
    input  logic          [NUM_REQ-1:0]   wr_lock,
    input  IntResAddr_t   [NUM_REQ-1:0]   rd_addr,
    input  IntResAddr_t   [NUM_REQ-1:0]   wr_addr,
    input  DataWidth_t    [NUM_REQ-1:0]   rd_width,
    input  DataWidth_t    [NUM_REQ-1:0]   wr_width,
    input  IntResDouble_t [NUM_REQ-1:0]   wr_data,
    output logic          [NUM_REQ-1:0]   rd_gnt,
    output logic          [NUM_REQ-1:0]   wr_gnt,
    output logic          [NUM_REQ-1:0]   rd_valid,
    output IntResDouble_t                 rd_data,
    output MemRdIn_t                      mem_rd,
    input  IntResDouble_t                 mem_rd_data,
    output MemWrIn_t                      mem_wr
`ifdef INT_RES_ARB_STATS_EN
    ,
    output logic          [NUM_REQ-1:0][15:0] stall_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    // Index 0 is the read port, index 1 the write port
    logic [NUM_REQ-1:0] port_req_s  [2];
    logic [NUM_REQ-1:0] port_lock_s [2];
    logic [NUM_REQ-1:0] port_gnt_s  [2];

    assign port_req_s[0]  = rd_req;
    assign port_req_s[1]  = wr_req;
    assign port_lock_s[0] = rd_lock;
    assign port_lock_s[1] = wr_lock;

    for (genvar p = 0; p < 2; p++) begin : g_port
        ArbState_t          state_q, state_d;
        logic [PTR_W-1:0]   ptr_q, ptr_d;
        logic [PTR_W-1:0]   owner_q, owner_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [CNT_W-1:0]   run_s;
        logic [NUM_REQ-1:0] rr_gnt_s;
        logic [NUM_REQ-1:0] gnt_s;
        logic [PTR_W-1:0]   gnt_idx_s;

        rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
            .req (port_req_s[p]),
            .ptr (ptr_q),
            .gnt (rr_gnt_s)
        );

        // State register: FSM state, round-robin pointer, lock owner and lock run length
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ARB_IDLE;
                ptr_q   <= '0;
                owner_q <= '0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                owner_q <= owner_d;
                cnt_q   <= cnt_d;
            end
        end

        // Output decode: a locked port serves only its owner, otherwise round-robin
        always_comb begin
            gnt_s = '0;
            if (!rst_n) begin
                gnt_s = '0;
            end else if (state_q == ARB_LOCKED) begin
                gnt_s[owner_q] = port_req_s[p][owner_q];
            end else begin
                gnt_s = rr_gnt_s;
            end
            gnt_idx_s = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                gnt_idx_s = gnt_idx_s | (gnt_s[i] ? PTR_W'(i) : '0);
            end
        end

        // Next state: lock entry/continuation, forced release after MAX_LOCK grants
        always_comb begin
            state_d = state_q;
            ptr_d   = ptr_q;
            owner_d = owner_q;
            cnt_d   = cnt_q;
            run_s   = ((state_q == ARB_LOCKED) ? cnt_q : '0) + CNT_W'(1);
            if (gnt_s == '0) begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end else if (port_lock_s[p][gnt_idx_s] && (run_s != CNT_W'(MAX_LOCK))) begin
                state_d = ARB_LOCKED;
                owner_d = gnt_idx_s;
                cnt_d   = run_s;
            end else begin
                // Unlocked grant, lock drop, or forced release: move pointer past the winner
                state_d = ((state_q == ARB_LOCKED) && !port_lock_s[p][gnt_idx_s]) ? ARB_IDLE : ARB_GRANT;
                ptr_d   = (gnt_idx_s == PTR_W'(NUM_REQ-1)) ? '0 : (gnt_idx_s + PTR_W'(1));
                cnt_d   = '0;
            end
        end

        assign port_gnt_s[p] = gnt_s;
    end

    assign rd_gnt = port_gnt_s[0];
    assign wr_gnt = port_gnt_s[1];

    IntResAddr_t   rd_addr_s, wr_addr_s;
    IntResDouble_t wr_data_s;
    logic          rd_w_s, wr_w_s;

    // Steer the granted requester's fields onto the memory ports; zero when idle
    always_comb begin
        rd_addr_s = '0;
        wr_addr_s = '0;
        wr_data_s = '0;
        rd_w_s    = 1'b0;
        wr_w_s    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_addr_s = rd_addr_s | ({ADDR_W{rd_gnt[i]}} & rd_addr[i]);
            wr_addr_s = wr_addr_s | ({ADDR_W{wr_gnt[i]}} & wr_addr[i]);
            wr_data_s = wr_data_s | ({DOUBLE_W{wr_gnt[i]}} & align_wr_data(wr_data[i], wr_width[i]));
            rd_w_s    = rd_w_s | (rd_gnt[i] & rd_width[i][0]);
            wr_w_s    = wr_w_s | (wr_gnt[i] & wr_width[i][0]);
        end
        mem_rd.en         = |rd_gnt;
        mem_rd.addr       = rd_addr_s;
        mem_rd.data_width = DataWidth_t'(rd_w_s);
        mem_wr.en         = |wr_gnt;
        mem_wr.chip_en    = rst_n;
        mem_wr.addr       = wr_addr_s;
        mem_wr.data       = wr_data_s;
        mem_wr.data_width = DataWidth_t'(wr_w_s);
    end

    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;

    // Read return tag: the requester granted this cycle receives data next cycle
    always_comb begin
        rd_valid_d = rd_gnt;
    end

    // Read-valid register; async reset drops any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = (|rd_valid_q) ? mem_rd_data : '0;

`ifdef INT_RES_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] stall_q, stall_d;
    logic [NUM_REQ-1:0]       stall_s;

    // A requester stalls when it asks on either port and is not granted there
    always_comb begin
        stall_s = (rd_req & ~rd_gnt) | (wr_req & ~wr_gnt);
        for (int i = 0; i < NUM_REQ; i++) begin
            stall_d[i] = (stall_s[i] && (stall_q[i] != 16'hFFFF)) ? (stall_q[i] + 16'd1) : stall_q[i];
        end
    end

    // Saturating stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_int_res_arbiter.sv
// Self-checking bench for int_res_arbiter: directed stimulus, scoreboard of
// expected read returns, external memory model with registered read.
module tb_int_res_arbiter;
    import Defines::*;

    logic                      clk;
    logic                      rst_n;
    logic          [2:0]       rd_req, wr_req, rd_lock, wr_lock;
    IntResAddr_t   [2:0]       rd_addr, wr_addr;
    DataWidth_t    [2:0]       rd_width, wr_width;
    IntResDouble_t [2:0]       wr_data;
    logic          [2:0]       rd_gnt, wr_gnt, rd_valid;
    IntResDouble_t             rd_data;
    MemRdIn_t                  mem_rd;
    IntResDouble_t             mem_rd_data;
    MemWrIn_t                  mem_wr;
`ifdef INT_RES_ARB_STATS_EN
    logic          [2:0][15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]    v;
        IntResDouble_t d;
    } sb_t;
    sb_t sb_q [$];

    localparam IntResDouble_t D5  = 64'hC0DE_0000_0000_0005;
    localparam IntResDouble_t D10 = 64'hC0DE_0000_0000_000A;
    localparam IntResDouble_t D11 = 64'hC0DE_0000_0000_000B;
    localparam IntResDouble_t D12 = 64'hC0DE_0000_0000_000C;

    int_res_arbiter #(.NUM_REQ(3), .MAX_LOCK(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .rd_lock     (rd_lock),
        .wr_lock     (wr_lock),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .rd_width    (rd_width),
        .wr_width    (wr_width),
        .wr_data     (wr_data),
        .rd_gnt      (rd_gnt),
        .wr_gnt      (wr_gnt),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .mem_rd      (mem_rd),
        .mem_rd_data (mem_rd_data),
        .mem_wr      (mem_wr)
`ifdef INT_RES_ARB_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read of pre-write contents, write at the same edge
    IntResDouble_t mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        mem_rd_data = '0;
        forever begin
            @(posedge clk);
            if (mem_rd.en) mem_rd_data <= mem[mem_rd.addr];
            if (mem_wr.en) mem[mem_wr.addr] <= mem_wr.data;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: every rd_valid must match the oldest outstanding expected read
    always @(negedge clk) begin : mon
        sb_t e;
        if (rd_valid !== 3'b000) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_spurious actual=%b expected=000", rd_valid);
            end else begin
                e = sb_q.pop_front();
                chk("rd_valid", 64'(rd_valid), 64'(e.v));
                chk("rd_data", rd_data, e.d);
            end
        end
    end

    // One arbitration cycle: check grants and memory ports, queue the read return
    task automatic step(input logic [2:0] e_rg, input logic [2:0] e_wg,
                        input IntResDouble_t e_rdata, input bit push);
        IntResAddr_t   ea_r, ea_w;
        IntResDouble_t ed_w;
        ea_r = '0;
        ea_w = '0;
        ed_w = '0;
        for (int i = 0; i < 3; i++) begin
            if (e_rg[i]) ea_r = rd_addr[i];
            if (e_wg[i]) begin
                ea_w = wr_addr[i];
                ed_w = (wr_width[i] == DOUBLE_WIDTH) ? wr_data[i] : {32'h0, wr_data[i][31:0]};
            end
        end
        @(negedge clk);
        chk("rd_gnt", 64'(rd_gnt), 64'(e_rg));
        chk("wr_gnt", 64'(wr_gnt), 64'(e_wg));
        chk("mem_rd_en", 64'(mem_rd.en), 64'(|e_rg));
        chk("mem_rd_addr", 64'(mem_rd.addr), 64'(ea_r));
        chk("mem_wr_en", 64'(mem_wr.en), 64'(|e_wg));
        chk("mem_wr_addr", 64'(mem_wr.addr), 64'(ea_w));
        chk("mem_wr_data", mem_wr.data, ed_w);
        chk("chip_en", 64'(mem_wr.chip_en), 64'd1);
        if (push && (e_rg != 3'b000)) sb_q.push_back('{v: e_rg, d: e_rdata});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [2:0] SEQ [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    localparam IntResDouble_t SEQ_D [6] = '{D10, D11, D12, D10, D11, D12};

    initial begin
        rst_n   = 1'b0;
        rd_req  = 3'b111;
        wr_req  = 3'b000;
        rd_lock = 3'b000;
        wr_lock = 3'b000;
        for (int i = 0; i < 3; i++) begin
            rd_addr[i]  = IntResAddr_t'(10 + i);
            wr_addr[i]  = '0;
            rd_width[i] = DOUBLE_WIDTH;
            wr_width[i] = DOUBLE_WIDTH;
            wr_data[i]  = '0;
        end

        // Reset state with requests already asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_gnt", 64'(rd_gnt), 64'd0);
        chk("rst_wr_gnt", 64'(wr_gnt), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_mem_rd_en", 64'(mem_rd.en), 64'd0);
        chk("rst_mem_wr_en", 64'(mem_wr.en), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin rotation on the read port
        for (int k = 0; k < 6; k++) step(SEQ[k], 3'b000, SEQ_D[k], 1'b1);
        rd_req = 3'b000;
        step(3'b000, 3'b000, '0, 1'b0);

        // Same-cycle read and write to addr 5: old data first, new data on re-read
        rd_req = 3'b001; rd_addr[0] = 8'd5;
        wr_req = 3'b010; wr_addr[1] = 8'd5; wr_data[1] = 64'hABCD1234; wr_width[1] = DOUBLE_WIDTH;
        step(3'b001, 3'b010, D5, 1'b1);
        wr_req = 3'b000;
        step(3'b001, 3'b000, 64'hABCD1234, 1'b1);

        // Single-width write keeps only the low half
        rd_req = 3'b000;
        wr_req = 3'b100; wr_addr[2] = 8'd6; wr_data[2] = 64'hFFFF_FFFF_1234_5678; wr_width[2] = SINGLE_WIDTH;
        step(3'b000, 3'b100, '0, 1'b0);
        wr_req = 3'b000; rd_req = 3'b001; rd_addr[0] = 8'd6;
        step(3'b001, 3'b000, 64'h0000_0000_1234_5678, 1'b1);

        // Write-port rotation, independent of the read pointer
        rd_req = 3'b000;
        wr_req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wr_addr[i]  = IntResAddr_t'(20 + i);
            wr_data[i]  = 64'h5555_0000_0000_0000 | 64'(i);
            wr_width[i] = DOUBLE_WIDTH;
        end
        step(3'b000, 3'b001, '0, 1'b0);
        step(3'b000, 3'b010, '0, 1'b0);
        step(3'b000, 3'b100, '0, 1'b0);
        wr_req = 3'b000;

        // Lock by requester 2: 16 grants, forced release to requester 0, relock
        rd_addr[0] = 8'd10;
        rd_req = 3'b100; rd_lock = 3'b100;
        step(3'b100, 3'b000, D12, 1'b1);
        rd_req = 3'b101;
        repeat (15) step(3'b100, 3'b000, D12, 1'b1);
        step(3'b001, 3'b000, D10, 1'b1);
        step(3'b100, 3'b000, D12, 1'b1);
        // Owner drops its request while locked: nobody is granted that cycle
        rd_req = 3'b001; rd_lock = 3'b000;
        step(3'b000, 3'b000, '0, 1'b0);
        rd_req = 3'b101;
        step(3'b100, 3'b000, D12, 1'b1);
        step(3'b001, 3'b000, D10, 1'b1);
        rd_req = 3'b000;
        step(3'b000, 3'b000, '0, 1'b0);

        // Reset right after a read grant cancels its return
        rd_req = 3'b001;
        step(3'b001, 3'b000, D10, 1'b0);
        rst_n  = 1'b0;
        rd_req = 3'b000;
        @(negedge clk);
        chk("cancel_rd_valid", 64'(rd_valid), 64'd0);
        chk("cancel_rd_data", rd_data, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("post_rst_rd_data", rd_data, 64'd0);
        chk("post_rst_rd_gnt", 64'(rd_gnt), 64'd0);
        chk("post_rst_mem_rd_en", 64'(mem_rd.en), 64'd0);
        chk("post_rst_mem_wr_en", 64'(mem_wr.en), 64'd0);
        @(posedge clk);
        #1;
        // Pointer was reset to 0, so requester 0 wins first
        rd_req = 3'b111;
        step(3'b001, 3'b000, D10, 1'b1);
        rd_req = 3'b000;
        step(3'b000, 3'b000, '0, 1'b0);

`ifdef INT_RES_ARB_STATS_EN
        // Stall counters: cleared by reset, count blocked cycles, saturate
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("stall0_rst", 64'(stall_cnt[0]), 64'd0);
        chk("stall1_rst", 64'(stall_cnt[1]), 64'd0);
        chk("stall2_rst", 64'(stall_cnt[2]), 64'd0);
        @(posedge clk);
        #1;
        wr_req = 3'b100; wr_lock = 3'b100; wr_addr[2] = 8'd30;
        step(3'b000, 3'b100, '0, 1'b0);
        wr_req = 3'b110;
        repeat (10) step(3'b000, 3'b100, '0, 1'b0);
        wr_req = 3'b000; wr_lock = 3'b000;
        step(3'b000, 3'b000, '0, 1'b0);
        @(negedge clk);
        chk("stall1_ten", 64'(stall_cnt[1]), 64'd10);
        chk("stall0_ten", 64'(stall_cnt[0]), 64'd0);
        chk("stall2_ten", 64'(stall_cnt[2]), 64'd0);
        @(posedge clk);
        #1;
        wr_req = 3'b110; wr_lock = 3'b100;
        repeat (70000) @(posedge clk);
        #1;
        wr_req = 3'b000; wr_lock = 3'b000;
        @(negedge clk);
        chk("stall1_sat", 64'(stall_cnt[1]), 64'h0000_0000_0000_FFFF);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
